// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding select for the in-order pipeline.
// Tracks DEPTH post-decode writer slots; stalls or bypasses decode sources.
module pipe_hazard_unit #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DEPTH               = 3,
  parameter int FWD_EN              = 1,
  parameter int ALU_READY           = 1,
  parameter int LOAD_READY          = 2,
  parameter int ZERO_REG_EN         = 0,
  parameter int STALL_CNT_BITS      = 16,
  localparam int FSEL_W = $clog2(DEPTH + 1),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2,
  input  logic                           dec_src1_used,
  input  logic                           dec_src2_used,
  input  logic                           dec_wr_reg,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dest,
  input  logic                           dec_is_load,
  input  logic                           flush,
  output logic                           stall,
  output logic [FSEL_W-1:0]              fwd_sel1,
  output logic [FSEL_W-1:0]              fwd_sel2,
  output logic [CNT_W-1:0]               inflight,
  output logic [STALL_CNT_BITS-1:0]      stall_cycles
);

  typedef logic [REG_INDEX_BIT_WIDTH-1:0] reg_t;

  logic [DEPTH-1:0] slot_v;
  logic [DEPTH-1:0] slot_ld;
  reg_t             slot_d [DEPTH];

  reg_t              src  [2];
  logic              used [2];
  logic              hit  [2];
  logic              rdy  [2];
  logic [FSEL_W-1:0] sel  [2];
  logic              pend [2];

  logic             stall_raw;
  logic             acc;
  logic [DEPTH-1:0] nxt_v;
  logic [CNT_W-1:0] nxt_cnt;

  assign src[0]  = dec_src1;
  assign src[1]  = dec_src2;
  assign used[0] = dec_src1_used;
  assign used[1] = dec_src2_used;

  // Scan oldest to youngest so the lowest matching slot wins.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit[s] = 1'b0;
      rdy[s] = 1'b0;
      sel[s] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_v[k] && slot_d[k] == src[s]) begin
          hit[s] = 1'b1;
          rdy[s] = (k >= (slot_ld[k] ? LOAD_READY : ALU_READY));
          sel[s] = FSEL_W'(k + 1);
        end
      end
      if (!(dec_valid && used[s]) ||
          (ZERO_REG_EN != 0 && src[s] == '0))
        hit[s] = 1'b0;
      pend[s] = hit[s] && (FWD_EN == 0 || !rdy[s]);
    end
  end

  assign stall_raw = pend[0] | pend[1];
  assign stall     = reset & ~flush & stall_raw;

  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (reset && FWD_EN != 0 && !stall) begin
      if (hit[0] && rdy[0]) fwd_sel1 = sel[0];
      if (hit[1] && rdy[1]) fwd_sel2 = sel[1];
    end
  end

  assign acc = dec_valid & dec_wr_reg & ~stall & ~flush;

  always_comb begin
    nxt_v[0] = acc;
    for (int k = 1; k < DEPTH; k++)
      nxt_v[k] = slot_v[k-1];
    nxt_cnt = '0;
    for (int k = 0; k < DEPTH; k++)
      nxt_cnt = nxt_cnt + CNT_W'(nxt_v[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_v       <= '0;
      slot_ld      <= '0;
      for (int k = 0; k < DEPTH; k++)
        slot_d[k] <= '0;
      inflight     <= '0;
      stall_cycles <= '0;
    end else begin
      slot_v     <= nxt_v;
      slot_ld[0] <= dec_is_load;
      slot_d[0]  <= dec_dest;
      for (int k = 1; k < DEPTH; k++) begin
        slot_ld[k] <= slot_ld[k-1];
        slot_d[k]  <= slot_d[k-1];
      end
      inflight <= nxt_cnt;
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: three builds driven in lockstep
// against a history-based model of accepted writers.
module tb_pipe_hazard_unit;

  localparam int NI = 3;
  localparam int HN = 4096;
  localparam int FWD [NI]  = '{1, 0, 1};
  localparam int ZER [NI]  = '{0, 0, 1};
  localparam int CBITS[NI] = '{16, 16, 3};

  logic       clk;
  logic       reset;
  logic       dec_valid;
  logic [3:0] dec_src1;
  logic [3:0] dec_src2;
  logic       dec_src1_used;
  logic       dec_src2_used;
  logic       dec_wr_reg;
  logic [3:0] dec_dest;
  logic       dec_is_load;
  logic       flush;

  logic        st  [NI];
  logic [1:0]  f1  [NI];
  logic [1:0]  f2  [NI];
  logic [1:0]  inf [NI];
  logic [15:0] sc0;
  logic [15:0] sc1;
  logic [2:0]  sc2;

  bit         acc_v [NI][HN];
  logic [3:0] acc_d [NI][HN];
  bit         acc_l [NI][HN];
  int         sc_m  [NI];
  int         cyc;
  int         n_ast;
  int         n_fail;

  pipe_hazard_unit u0 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
    .dec_wr_reg(dec_wr_reg), .dec_dest(dec_dest),
    .dec_is_load(dec_is_load), .flush(flush),
    .stall(st[0]), .fwd_sel1(f1[0]), .fwd_sel2(f2[0]),
    .inflight(inf[0]), .stall_cycles(sc0)
  );

  pipe_hazard_unit #(.FWD_EN(0)) u1 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
    .dec_wr_reg(dec_wr_reg), .dec_dest(dec_dest),
    .dec_is_load(dec_is_load), .flush(flush),
    .stall(st[1]), .fwd_sel1(f1[1]), .fwd_sel2(f2[1]),
    .inflight(inf[1]), .stall_cycles(sc1)
  );

  pipe_hazard_unit #(.ZERO_REG_EN(1), .STALL_CNT_BITS(3)) u2 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
    .dec_wr_reg(dec_wr_reg), .dec_dest(dec_dest),
    .dec_is_load(dec_is_load), .flush(flush),
    .stall(st[2]), .fwd_sel1(f1[2]), .fwd_sel2(f2[2]),
    .inflight(inf[2]), .stall_cycles(sc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int get_sc(input int i);
    case (i)
      0: return int'(sc0);
      1: return int'(sc1);
      default: return int'(sc2);
    endcase
  endfunction

  task automatic chk(input string tag, input int i,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_ast++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[u%0d] cyc=%0d: observed %0h expected %0h",
             tag, i, cyc, obs, exp);
    end
  endtask

  // Slot k during cycle c holds whatever was accepted from cycle c-1-k.
  function automatic int youngest(input int i, input logic [3:0] r,
                                  input bit u);
    if (!(dec_valid && u)) return -1;
    if (ZER[i] != 0 && r == 4'd0) return -1;
    for (int k = 0; k < 3; k++) begin
      int c = cyc - 1 - k;
      if (c >= 0 && acc_v[i][c] && acc_d[i][c] == r) return k;
    end
    return -1;
  endfunction

  function automatic bit ready_at(input int i, input int k);
    int need = acc_l[i][cyc-1-k] ? 2 : 1;
    return k >= need;
  endfunction

  task automatic drive(input bit we, input bit rs,
                       input bit v, input bit wr, input logic [3:0] d,
                       input bit l, input logic [3:0] a, input bit ua,
                       input logic [3:0] b, input bit ub, input bit fl);
    if (we) @(negedge clk);
    reset = rs; dec_valid = v; dec_wr_reg = wr; dec_dest = d;
    dec_is_load = l; dec_src1 = a; dec_src1_used = ua;
    dec_src2 = b; dec_src2_used = ub; flush = fl;
    #1;
    for (int i = 0; i < NI; i++) begin
      int  k1, k2, n;
      bit  r1, r2, es;
      int  e1, e2;
      if (!rs) begin
        for (int j = 0; j <= cyc; j++) acc_v[i][j] = 1'b0;
        sc_m[i] = 0;
      end
      k1 = youngest(i, a, ua);
      k2 = youngest(i, b, ub);
      r1 = (k1 >= 0) && ready_at(i, k1);
      r2 = (k2 >= 0) && ready_at(i, k2);
      es = rs && !fl &&
           ((k1 >= 0 && (FWD[i] == 0 || !r1)) ||
            (k2 >= 0 && (FWD[i] == 0 || !r2)));
      e1 = (rs && FWD[i] != 0 && !es && r1) ? k1 + 1 : 0;
      e2 = (rs && FWD[i] != 0 && !es && r2) ? k2 + 1 : 0;
      n = 0;
      for (int k = 0; k < 3; k++)
        if (cyc - 1 - k >= 0 && acc_v[i][cyc-1-k]) n++;
      chk("stall", i, 32'(st[i]), 32'(es));
      chk("fwd_sel1", i, 32'(f1[i]), 32'(e1));
      chk("fwd_sel2", i, 32'(f2[i]), 32'(e2));
      chk("inflight", i, 32'(inf[i]), 32'(n));
      chk("stall_cycles", i, 32'(get_sc(i)), 32'(sc_m[i]));
      acc_v[i][cyc] = rs && v && wr && !es && !fl;
      acc_d[i][cyc] = d;
      acc_l[i][cyc] = l;
      if (rs && es && sc_m[i] < (1 << CBITS[i]) - 1) sc_m[i]++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++)
      drive(1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0);
  endtask

  initial begin
    n_ast = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < NI; i++) sc_m[i] = 0;
    reset = 0; dec_valid = 0; dec_wr_reg = 0; dec_dest = 0;
    dec_is_load = 0; dec_src1 = 0; dec_src2 = 0;
    dec_src1_used = 0; dec_src2_used = 0; flush = 0;

    drive(1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0);
    drive(1, 0, 1, 1, 4'd3, 0, 4'd3, 1, 4'd3, 1, 0);

    // ALU producer then dependent ALU consumer
    drive(1, 1, 1, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 0);
    drive(1, 1, 1, 1, 4'd4, 0, 4'd3, 1, 4'd0, 0, 0);
    chk("add_c1_stall", 0, 32'(st[0]), 32'd1);
    chk("add_c1_fsel1", 0, 32'(f1[0]), 32'd0);
    drive(1, 1, 1, 1, 4'd4, 0, 4'd3, 1, 4'd0, 0, 0);
    chk("add_c2_stall", 0, 32'(st[0]), 32'd0);
    chk("add_c2_fsel1", 0, 32'(f1[0]), 32'd2);
    drive(1, 1, 1, 1, 4'd4, 0, 4'd3, 1, 4'd0, 0, 0);
    chk("add_sc", 0, 32'(sc0), 32'd1);
    chk("nofwd_c3_stall", 1, 32'(st[1]), 32'd1);
    drive(1, 1, 1, 1, 4'd4, 0, 4'd3, 1, 4'd0, 0, 0);
    chk("nofwd_c4_stall", 1, 32'(st[1]), 32'd0);
    chk("nofwd_c4_fsel1", 1, 32'(f1[1]), 32'd0);
    chk("nofwd_sc", 1, 32'(sc1), 32'd3);
    idle(4);

    // Load-use on src2
    drive(1, 1, 1, 1, 4'd5, 1, 4'd0, 0, 4'd0, 0, 0);
    drive(1, 1, 1, 1, 4'd6, 0, 4'd0, 0, 4'd5, 1, 0);
    chk("ld_c1_stall", 0, 32'(st[0]), 32'd1);
    drive(1, 1, 1, 1, 4'd6, 0, 4'd0, 0, 4'd5, 1, 0);
    chk("ld_c2_stall", 0, 32'(st[0]), 32'd1);
    drive(1, 1, 1, 1, 4'd6, 0, 4'd0, 0, 4'd5, 1, 0);
    chk("ld_c3_stall", 0, 32'(st[0]), 32'd0);
    chk("ld_c3_fsel2", 0, 32'(f2[0]), 32'd3);
    idle(4);

    // Two writers of r2; the younger one must be selected
    drive(1, 1, 1, 1, 4'd2, 0, 4'd0, 0, 4'd0, 0, 0);
    drive(1, 1, 1, 1, 4'd2, 0, 4'd0, 0, 4'd0, 0, 0);
    drive(1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0);
    drive(1, 1, 1, 0, 4'd0, 0, 4'd2, 1, 4'd2, 1, 0);
    chk("young_fsel1", 0, 32'(f1[0]), 32'd2);
    chk("young_fsel2", 0, 32'(f2[0]), 32'd2);
    chk("young_stall", 0, 32'(st[0]), 32'd0);
    idle(4);

    // Flush overrides a pending stall and inserts a bubble
    drive(1, 1, 1, 1, 4'd6, 0, 4'd0, 0, 4'd0, 0, 0);
    drive(1, 1, 1, 1, 4'd7, 0, 4'd6, 1, 4'd0, 0, 1);
    chk("flush_stall", 0, 32'(st[0]), 32'd0);
    drive(1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0);
    chk("flush_inflight", 0, 32'(inf[0]), 32'd1);
    idle(4);

    // Asynchronous reset while a load-use stall is active
    drive(1, 1, 1, 1, 4'd3, 1, 4'd0, 0, 4'd0, 0, 0);
    drive(1, 1, 1, 1, 4'd8, 0, 4'd3, 1, 4'd0, 0, 0);
    chk("prerst_c1_stall", 0, 32'(st[0]), 32'd1);
    @(negedge clk);
    chk("prerst_c2_stall", 0, 32'(st[0]), 32'd1);
    drive(0, 0, 1, 1, 4'd8, 0, 4'd3, 1, 4'd0, 0, 0);
    chk("rst_stall", 0, 32'(st[0]), 32'd0);
    chk("rst_inflight", 0, 32'(inf[0]), 32'd0);
    chk("rst_sc", 0, 32'(sc0), 32'd0);

    // Register zero never creates a hazard in the ZERO_REG_EN build
    drive(1, 1, 1, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0);
    drive(1, 1, 1, 0, 4'd0, 0, 4'd0, 1, 4'd0, 0, 0);
    chk("zero_stall", 2, 32'(st[2]), 32'd0);
    chk("zero_fsel1", 2, 32'(f1[2]), 32'd0);
    chk("zero_nz_stall", 0, 32'(st[0]), 32'd1);
    idle(4);

    for (int n = 0; n < 1500; n++) begin
      bit rs = ($urandom_range(0, 199) != 0);
      drive(1, rs,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
            4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_ast, n_fail);
    $finish;
  end

endmodule
